// File: rtl/alu_uart_interface_pkg.sv
// rtl/alu_uart_interface_pkg.sv - shared opcodes and FSM state encoding for the ALU/UART sequencer
//
// Purpose : single source of the ALU opcode constants and the sequencer state type.
// Ports   : none (package).

package alu_uart_interface_pkg;

    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_SRL = 8'h02;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_NOR = 8'h27;

    localparam int NUM_OPS = 8;

    // Opcodes the sequencer forwards to the ALU; anything else (including 0x00) is rejected.
    localparam logic [7:0] SUPPORTED_OPS [NUM_OPS] = '{
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRL, OP_SRA, OP_NOR
    };

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

endpackage

// File: rtl/alu_uart_interface_frame_timeout.sv
// rtl/alu_uart_interface_frame_timeout.sv - inter-byte idle timer for one RX frame
//
// Purpose : counts idle cycles while enabled; flags the cycle on which the limit is reached.
// Ports   : clk     in  system clock
//           reset   in  synchronous active-high reset
//           clear   in  force counter to zero (byte accepted / not inside a frame)
//           enable  in  count this cycle
//           expired out high during the TIMEOUT_CYCLES-th consecutive enabled idle cycle

module alu_uart_interface_frame_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Combinational so the FSM can react in the same cycle; clear has priority so a
    // byte arriving on the expiry cycle still wins.
    assign expired = enable && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            if (expired) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_uart_interface.sv
// rtl/alu_uart_interface.sv - sequencer between UART RX/TX byte links and the combinational ALU
//
// Purpose : gathers A, B and opcode bytes from the receiver, presents them to the ALU,
//           captures the result and hands it to the transmitter as a single byte.
// Ports   : i_clk, i_reset           clock, synchronous active-high reset
//           i_rx_data, i_rx_done     received byte and its 1-cycle strobe
//           o_dato_a, o_dato_b       registered ALU operands
//           o_op_code                registered ALU opcode
//           i_resultado              combinational ALU result
//           o_tx_data, o_tx_start    result byte and 1-cycle start strobe to the transmitter
//           i_tx_done                1-cycle strobe from the transmitter
//           o_op_error               1-cycle pulse: unsupported opcode, frame discarded
//           o_rx_overrun             1-cycle pulse: byte arrived while a result was pending

module alu_uart_interface
    import alu_uart_interface_pkg::*;
#(
    parameter int OPERAND_SIZE   = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [OPERAND_SIZE-1:0] i_rx_data,
    input  logic                    i_rx_done,
    output logic [OPERAND_SIZE-1:0] o_dato_a,
    output logic [OPERAND_SIZE-1:0] o_dato_b,
    output logic [OPERAND_SIZE-1:0] o_op_code,
    input  logic [OPERAND_SIZE-1:0] i_resultado,
    output logic [OPERAND_SIZE-1:0] o_tx_data,
    output logic                    o_tx_start,
    input  logic                    i_tx_done,
    output logic                    o_op_error,
    output logic                    o_rx_overrun
);

    state_t state, state_next;

    logic [OPERAND_SIZE-1:0] dato_a_next;
    logic [OPERAND_SIZE-1:0] dato_b_next;
    logic [OPERAND_SIZE-1:0] op_code_next;
    logic [OPERAND_SIZE-1:0] tx_data_next;
    logic                    tx_start_next;
    logic                    op_error_next;
    logic                    rx_overrun_next;

    logic op_ok;
    logic timer_enable;
    logic timer_clear;
    logic timer_expired;

    // Opcode constants are 8 bits; wider operand sizes compare against them zero-extended.
    always_comb begin
        op_ok = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (i_rx_data == OPERAND_SIZE'(SUPPORTED_OPS[i])) begin
                op_ok = 1'b1;
            end
        end
    end

    // Timer only runs between bytes of a frame; outside those states it is held at zero,
    // which also gives the clear-on-entry-to-WAIT_A behaviour.
    assign timer_enable = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
    assign timer_clear  = i_rx_done || !timer_enable;

    alu_uart_interface_frame_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timeout (
        .clk     (i_clk),
        .reset   (i_reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        state_next      = state;
        dato_a_next     = o_dato_a;
        dato_b_next     = o_dato_b;
        op_code_next    = o_op_code;
        tx_data_next    = o_tx_data;
        tx_start_next   = 1'b0;
        op_error_next   = 1'b0;
        rx_overrun_next = 1'b0;

        case (state)
            ST_WAIT_A: begin
                if (i_rx_done) begin
                    dato_a_next = i_rx_data;
                    state_next  = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (i_rx_done) begin
                    dato_b_next = i_rx_data;
                    state_next  = ST_WAIT_OP;
                end else if (timer_expired) begin
                    state_next = ST_WAIT_A;
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done) begin
                    if (op_ok) begin
                        op_code_next = i_rx_data;
                        state_next   = ST_EXEC;
                    end else begin
                        op_error_next = 1'b1;
                        state_next    = ST_WAIT_A;
                    end
                end else if (timer_expired) begin
                    state_next = ST_WAIT_A;
                end
            end
            ST_EXEC: begin
                // Operands/opcode have been stable on the ALU for a full cycle here.
                tx_data_next    = i_resultado;
                rx_overrun_next = i_rx_done;
                state_next      = ST_SEND;
            end
            ST_SEND: begin
                tx_start_next   = 1'b1;
                rx_overrun_next = i_rx_done;
                state_next      = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                rx_overrun_next = i_rx_done;
                if (i_tx_done) begin
                    state_next = ST_WAIT_A;
                end
            end
            default: begin
                state_next = ST_WAIT_A;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_WAIT_A;
            o_dato_a     <= '0;
            o_dato_b     <= '0;
            o_op_code    <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_op_error   <= 1'b0;
            o_rx_overrun <= 1'b0;
        end else begin
            state        <= state_next;
            o_dato_a     <= dato_a_next;
            o_dato_b     <= dato_b_next;
            o_op_code    <= op_code_next;
            o_tx_data    <= tx_data_next;
            o_tx_start   <= tx_start_next;
            o_op_error   <= op_error_next;
            o_rx_overrun <= rx_overrun_next;
        end
    end

endmodule

// File: tb/tb_alu_uart_interface.sv
// tb/tb_alu_uart_interface.sv - directed self-checking bench for alu_uart_interface

module tb_alu_uart_interface;

    localparam int OS = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [OS-1:0] rx_data = '0;
    logic          rx_done = 1'b0;
    logic [OS-1:0] dato_a, dato_b, op_code, resultado, tx_data;
    logic          tx_start, tx_done, op_error, rx_overrun;

    int total = 0;
    int bad = 0;

    int n_start = 0;
    int n_err = 0;
    int n_ov = 0;
    int tx_cnt = 0;

    always #5 clk = ~clk;

    alu_uart_interface #(
        .OPERAND_SIZE   (OS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .o_dato_a     (dato_a),
        .o_dato_b     (dato_b),
        .o_op_code    (op_code),
        .i_resultado  (resultado),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .i_tx_done    (tx_done),
        .o_op_error   (op_error),
        .o_rx_overrun (rx_overrun)
    );

    function automatic logic [OS-1:0] alu(input logic [OS-1:0] a, input logic [OS-1:0] b,
                                          input logic [OS-1:0] op);
        case (op)
            8'h20:   return a + b;
            8'h22:   return a - b;
            8'h24:   return a & b;
            8'h25:   return a | b;
            8'h26:   return a ^ b;
            8'h27:   return ~(a | b);
            8'h02:   return b >> a;
            8'h03:   return OS'($signed(b) >>> a);
            default: return '0;
        endcase
    endfunction

    assign resultado = alu(dato_a, dato_b, op_code);

    // UART TX model: tx_done pulses about 10 cycles after a start pulse.
    initial tx_done = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            tx_cnt  <= 0;
            tx_done <= 1'b0;
        end else if (tx_start) begin
            tx_cnt  <= 9;
            tx_done <= 1'b0;
        end else if (tx_cnt == 1) begin
            tx_cnt  <= 0;
            tx_done <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (tx_start)   n_start++;
        if (op_error)   n_err++;
        if (rx_overrun) n_ov++;
    end

    // Called at a negedge; the byte is sampled on the following posedge.
    task automatic send_byte(input logic [OS-1:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_op_and_check(input logic [OS-1:0] op, input logic [OS-1:0] exp,
                                     input string name);
        send_byte(op);
        total++;
        if (tx_start !== 1'b0) begin
            bad++; $display("FAIL %s start_n1 got=%b exp=0", name, tx_start);
        end
        @(negedge clk);
        total++;
        if (tx_start !== 1'b0) begin
            bad++; $display("FAIL %s start_n2 got=%b exp=0", name, tx_start);
        end
        @(negedge clk);
        total++;
        if (tx_start !== 1'b1) begin
            bad++; $display("FAIL %s start_n3 got=%b exp=1", name, tx_start);
        end
        total++;
        if (tx_data !== exp) begin
            bad++; $display("FAIL %s tx_data got=%h exp=%h", name, tx_data, exp);
        end
        @(negedge clk);
        total++;
        if (tx_start !== 1'b0) begin
            bad++; $display("FAIL %s start_width got=%b exp=0", name, tx_start);
        end
    endtask

    task automatic start_frame(input logic [OS-1:0] a, input logic [OS-1:0] b,
                               input logic [OS-1:0] op, input logic [OS-1:0] exp,
                               input string name);
        send_byte(a);
        send_byte(b);
        send_op_and_check(op, exp, name);
    endtask

    task automatic finish_frame(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL %s tx_done_timeout got=0 exp=1", name);
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [OS-1:0] a, input logic [OS-1:0] b,
                             input logic [OS-1:0] op, input logic [OS-1:0] exp,
                             input string name);
        int st0;
        st0 = n_start;
        start_frame(a, b, op, exp, name);
        finish_frame(name);
        total++;
        if (n_start - st0 !== 1) begin
            bad++; $display("FAIL %s start_count got=%0d exp=1", name, n_start - st0);
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({dato_a, dato_b, op_code, tx_data} !== 32'h0) begin
            bad++; $display("FAIL %s regs got=%h exp=0", name, {dato_a, dato_b, op_code, tx_data});
        end
        total++;
        if ({tx_start, op_error, rx_overrun} !== 3'b000) begin
            bad++; $display("FAIL %s pulses got=%b exp=000", name, {tx_start, op_error, rx_overrun});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset");
        @(negedge clk);
        total++;
        if (tx_start !== 1'b0) begin
            bad++; $display("FAIL reset_no_start got=%b exp=0", tx_start);
        end
    endtask

    task automatic test_add();
        run_frame(8'h05, 8'h03, 8'h20, 8'h08, "add");
    endtask

    task automatic test_back_to_back();
        run_frame(8'h03, 8'h05, 8'h22, 8'hFE, "sub");
        run_frame(8'hF0, 8'h0F, 8'h27, 8'h00, "nor_b2b");
    endtask

    task automatic test_op_error();
        int e0, s0;
        e0 = n_err;
        s0 = n_start;
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h55);
        total++;
        if (op_error !== 1'b1) begin
            bad++; $display("FAIL op_error_pulse got=%b exp=1", op_error);
        end
        repeat (5) @(negedge clk);
        total++;
        if (n_err - e0 !== 1) begin
            bad++; $display("FAIL op_error_count got=%0d exp=1", n_err - e0);
        end
        total++;
        if (n_start !== s0) begin
            bad++; $display("FAIL op_error_no_start got=%0d exp=%0d", n_start, s0);
        end
        total++;
        if (op_code !== 8'h27) begin
            bad++; $display("FAIL op_error_opcode_kept got=%h exp=27", op_code);
        end
        run_frame(8'h01, 8'h01, 8'h20, 8'h02, "after_error");
    endtask

    task automatic test_overrun();
        int o0;
        start_frame(8'h3C, 8'h0F, 8'h26, 8'h33, "xor");
        o0 = n_ov;
        send_byte(8'hAA);
        total++;
        if (rx_overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_pulse got=%b exp=1", rx_overrun);
        end
        @(negedge clk);
        total++;
        if (n_ov - o0 !== 1) begin
            bad++; $display("FAIL overrun_count got=%0d exp=1", n_ov - o0);
        end
        total++;
        if (tx_data !== 8'h33 || dato_a !== 8'h3C) begin
            bad++; $display("FAIL overrun_kept got=%h/%h exp=33/3c", tx_data, dato_a);
        end
        finish_frame("overrun");
        run_frame(8'h09, 8'h04, 8'h22, 8'h05, "after_overrun");
    endtask

    task automatic test_timeout();
        send_byte(8'h07);
        repeat (TO) @(negedge clk);
        total++;
        if (dato_a !== 8'h07) begin
            bad++; $display("FAIL timeout_a_kept got=%h exp=07", dato_a);
        end
        run_frame(8'h01, 8'h02, 8'h25, 8'h03, "after_timeout");
        // B arrives on the 16th idle cycle, the expiry cycle itself.
        send_byte(8'h09);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h06);
        total++;
        if (dato_b !== 8'h06) begin
            bad++; $display("FAIL timeout_edge_b got=%h exp=06", dato_b);
        end
        send_op_and_check(8'h20, 8'h0F, "timeout_edge");
        finish_frame("timeout_edge");
    endtask

    task automatic test_reset_mid();
        int s0;
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset_wait_op");
        start_frame(8'h04, 8'h02, 8'h20, 8'h06, "pre_reset_tx");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        s0 = n_start;
        check_all_zero("reset_wait_tx");
        repeat (15) @(negedge clk);
        total++;
        if (n_start !== s0) begin
            bad++; $display("FAIL reset_no_stray_start got=%0d exp=%0d", n_start, s0);
        end
        run_frame(8'h02, 8'h03, 8'h24, 8'h02, "after_reset");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_back_to_back();
        test_op_error();
        test_overrun();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
